// File: rtl/rsa_pkg.sv
// rsa_pkg: shared operand widths, P-192 Montgomery constants
// and the mod_exp state codes.
package rsa_pkg;

  localparam int K     = 192;
  localparam int LOGK  = 8;
  localparam int EW    = 192;
  localparam int LOGEW = 8;

  localparam logic [K-1:0] M =
    192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

  // R mod M, i.e. Montgomery form of 1.
  localparam logic [K-1:0] R_MOD_M =
    192'h1_0000000000000001;

  // R^2 mod M, used to bring the base into Montgomery form.
  localparam logic [K-1:0] R2_MOD_M =
    192'h1_0000000000000002_0000000000000001;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SQR  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  // States in which an operand pair is presented to mod_mul.
  function automatic logic is_op_state(
    input logic [2:0] s
  );
    return (s == S_PRE) || (s == S_SQR) ||
           (s == S_MUL) || (s == S_POST);
  endfunction

endpackage

// File: rtl/mod_mul.sv
// mod_mul: bit-serial radix-2 Montgomery multiplier,
// z = a*b*2^-K mod M for a,b < M.
// Ports: clk, rst_n (sync, active-low), start (held until
// done), a/b operands (stable while start=1), done (one
// cycle), z (reduced product, valid while done=1).
// start is sampled in IDLE; done follows K cycles later,
// so start is high for K+1 cycles including the done cycle.
module mod_mul #(
  parameter int          K    = 192,
  parameter int          LOGK = 8,
  parameter logic [K-1:0] M   = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic         done,
  output logic [K-1:0] z
);

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_FIX  = 2'd2;

  logic [1:0]      state;
  logic [K-1:0]    a_sh;
  logic [K-1:0]    b_reg;
  logic [K:0]      t;
  logic [LOGK-1:0] cnt;
  logic [K-1:0]    t_sub;
  logic            t_ge;

  // One Montgomery step. t stays below 2M, so the sum
  // t + b + M needs K+2 bits and the halved result K+1.
  function automatic logic [K:0] mont_step(
    input logic [K:0]   t_in,
    input logic         a_bit,
    input logic [K-1:0] b_in
  );
    logic [K+1:0] s;
    s = {1'b0, t_in};
    if (a_bit) s = s + {2'b00, b_in};
    if (s[0])  s = s + {2'b00, M};
    return s[K+1:1];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= M_IDLE;
      a_sh  <= '0;
      b_reg <= '0;
      t     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        M_IDLE: begin
          if (start) begin
            // bit 0 is folded into the accept cycle
            b_reg <= b;
            a_sh  <= a >> 1;
            t     <= mont_step('0, a[0], b);
            cnt   <= LOGK'(1);
            state <= M_RUN;
          end
        end
        M_RUN: begin
          t    <= mont_step(t, a_sh[0], b_reg);
          a_sh <= a_sh >> 1;
          cnt  <= cnt + LOGK'(1);
          if (cnt == LOGK'(K - 1)) state <= M_FIX;
        end
        M_FIX: state <= M_IDLE;
        default: state <= M_IDLE;
      endcase
    end
  end

  // t < 2M, so one conditional subtract fully reduces it
  // and the low K bits of t - M are exact.
  assign t_ge  = (t >= {1'b0, M});
  assign t_sub = t[K-1:0] - M;
  assign z     = t_ge ? t_sub : t[K-1:0];
  assign done  = (state == M_FIX);

endmodule

// File: rtl/mod_exp.sv
// mod_exp: Montgomery modular exponentiation z = x^e mod M,
// left-to-right square-and-multiply over one mod_mul.
// Ports: clk, rst (sync, active-high), start (sampled in
// IDLE), x (base < M), e (exponent), busy, done (one-cycle
// pulse), z (result, held until the next run updates it).
// Option MOD_EXP_SKIP_LZ_EN: skip leading zero exponent
// bits after PRE with a serial scan, no mod_mul traffic.
module mod_exp #(
  parameter int           K        = rsa_pkg::K,
  parameter int           LOGK     = rsa_pkg::LOGK,
  parameter int           EW       = rsa_pkg::EW,
  parameter int           LOGEW    = rsa_pkg::LOGEW,
  parameter logic [K-1:0] M        = rsa_pkg::M,
  parameter logic [K-1:0] R_MOD_M  = rsa_pkg::R_MOD_M,
  parameter logic [K-1:0] R2_MOD_M = rsa_pkg::R2_MOD_M
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [K-1:0]  x,
  input  logic [EW-1:0] e,
  output logic          busy,
  output logic          done,
  output logic [K-1:0]  z
);

  import rsa_pkg::*;

  logic [2:0]       state;
  logic [2:0]       op_sel;
  logic [K-1:0]     x_bar;
  logic [K-1:0]     acc;
  logic [K-1:0]     z_q;
  logic [EW-1:0]    e_reg;
  logic [LOGEW-1:0] idx;

  logic             mul_rst_n;
  logic             mul_start;
  logic [K-1:0]     mul_a;
  logic [K-1:0]     mul_b;
  logic [K-1:0]     mul_z;
  logic             mul_done;

  logic [2:0]       gap_next;
  logic [LOGEW-1:0] gap_idx;
  logic             last_bit;
  logic             cur_bit;

  assign mul_rst_n = ~rst;

  mod_mul #(
    .K    (K),
    .LOGK (LOGK),
    .M    (M)
  ) u_mul (
    .clk   (clk),
    .rst_n (mul_rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .z     (mul_z)
  );

  // Operands come only from registers that change on
  // mul_done, so they are stable while mul_start is high.
  always_comb begin
    mul_start = 1'b0;
    mul_a     = acc;
    mul_b     = acc;
    unique case (state)
      S_PRE: begin
        mul_start = 1'b1;
        mul_a     = x_bar;
        mul_b     = R2_MOD_M;
      end
      S_SQR: mul_start = 1'b1;
      S_MUL: begin
        mul_start = 1'b1;
        mul_b     = x_bar;
      end
      S_POST: begin
        mul_start = 1'b1;
        mul_b     = K'(1);
      end
      default: mul_start = 1'b0;
    endcase
  end

  assign last_bit = (idx == '0);
  assign cur_bit  = e_reg[idx];

  // Successor of GAP, chosen by the op just finished.
  always_comb begin
    gap_next = S_FIN;
    gap_idx  = idx;
    unique case (op_sel)
      S_PRE: begin
`ifdef MOD_EXP_SKIP_LZ_EN
        // stay in GAP while scanning leading zeros
        if (cur_bit) begin
          gap_next = S_SQR;
        end else if (last_bit) begin
          gap_next = S_POST;
        end else begin
          gap_next = S_GAP;
          gap_idx  = idx - LOGEW'(1);
        end
`else
        gap_next = S_SQR;
`endif
      end
      S_SQR: begin
        if (cur_bit) begin
          gap_next = S_MUL;
        end else if (last_bit) begin
          gap_next = S_POST;
        end else begin
          gap_next = S_SQR;
          gap_idx  = idx - LOGEW'(1);
        end
      end
      S_MUL: begin
        if (last_bit) begin
          gap_next = S_POST;
        end else begin
          gap_next = S_SQR;
          gap_idx  = idx - LOGEW'(1);
        end
      end
      default: gap_next = S_FIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_sel <= S_IDLE;
      x_bar  <= '0;
      acc    <= '0;
      e_reg  <= '0;
      idx    <= '0;
      z_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_bar <= x;
            e_reg <= e;
            acc   <= R_MOD_M;
            idx   <= LOGEW'(EW - 1);
            state <= S_PRE;
          end
        end
        S_PRE, S_SQR, S_MUL, S_POST: begin
          if (mul_done) begin
            op_sel <= state;
            state  <= S_GAP;
            if (state == S_PRE)       x_bar <= mul_z;
            else if (state == S_POST) z_q   <= mul_z;
            else                      acc   <= mul_z;
          end
        end
        S_GAP: begin
          state <= gap_next;
          idx   <= gap_idx;
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = is_op_state(state) || (state == S_GAP);
  assign done = (state == S_FIN);
  assign z    = z_q;

endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: randomized and directed checks of mod_exp
// at K=EW=32 against a right-to-left pow-mod model.
module tb_mod_exp;

  localparam int K     = 32;
  localparam int LOGK  = 6;
  localparam int EW    = 32;
  localparam int LOGEW = 6;
  localparam logic [K-1:0] MODV = 32'hFFFF_FFFB;
  localparam longint unsigned MOD = 64'd4294967291;
  localparam int T_MUL = K + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [K-1:0]  x;
  logic [EW-1:0] e;
  logic          busy;
  logic          done;
  logic [K-1:0]  z;

  int   checks = 0;
  int   errors = 0;
  int   mul_starts = 0;
  int   done_cnt = 0;
  logic ms_q = 1'b0;

  mod_exp #(
    .K        (K),
    .LOGK     (LOGK),
    .EW       (EW),
    .LOGEW    (LOGEW),
    .M        (MODV),
    .R_MOD_M  (32'd5),
    .R2_MOD_M (32'd25)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .e     (e),
    .busy  (busy),
    .done  (done),
    .z     (z)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.mul_start && !ms_q) mul_starts++;
    ms_q = dut.mul_start;
    if (done) done_cnt++;
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic longint unsigned pow_mod(
    input longint unsigned b,
    input longint unsigned ex
  );
    longint unsigned r;
    longint unsigned bb;
    longint unsigned ee;
    r  = 1;
    bb = b % MOD;
    ee = ex;
    while (ee != 0) begin
      if (ee[0]) r = (r * bb) % MOD;
      bb = (bb * bb) % MOD;
      ee = ee >> 1;
    end
    return r % MOD;
  endfunction

  function automatic int lzc(input logic [EW-1:0] ev);
    for (int i = EW - 1; i >= 0; i--)
      if (ev[i]) return EW - 1 - i;
    return EW;
  endfunction

  function automatic int exp_nops(input logic [EW-1:0] ev);
`ifdef MOD_EXP_SKIP_LZ_EN
    return 2 + (EW - lzc(ev)) + $countones(ev);
`else
    return 2 + EW + $countones(ev);
`endif
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic launch(
    input logic [K-1:0]  xv,
    input logic [EW-1:0] ev
  );
    @(posedge clk);
    #1;
    x     = xv;
    e     = ev;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // cyc: index of the done cycle, accept cycle being 0
  task automatic wait_done(input string tag, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
    end
    check({tag, "_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic run(
    input string         tag,
    input logic [K-1:0]  xv,
    input logic [EW-1:0] ev,
    input logic [K-1:0]  zexp
  );
    int cyc;
    int ms0;
    int dc0;
    int nops;
    int lo;
    ms0 = mul_starts;
    dc0 = done_cnt;
    launch(xv, ev);
    wait_done(tag, cyc);
    check({tag, "_z"}, 64'(z), 64'(zexp));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    nops = exp_nops(ev);
    lo   = 1 + nops * (T_MUL + 1) + 1;
`ifdef MOD_EXP_SKIP_LZ_EN
    check({tag, "_lat"},
          64'((cyc + 1 >= lo) && (cyc + 1 <= lo + lzc(ev))),
          64'd1);
`else
    check({tag, "_lat"}, 64'(cyc + 1), 64'(lo));
`endif
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_ops"}, 64'(mul_starts - ms0), 64'(nops));
    check({tag, "_ndone"}, 64'(done_cnt - dc0), 64'd1);
  endtask

  initial begin
    logic [K-1:0]  xa;
    logic [EW-1:0] ea;
    logic [K-1:0]  zinv;
    int            cyc;
    int            dc0;

    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    e     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run("x2_e10", 32'd2, 32'd10, 32'd1024);
    run("e0", 32'd5, 32'd0, 32'd1);
    run("x0", 32'd0, 32'd3, 32'd0);
    run("xm1", MODV - 32'd1, 32'd2, 32'd1);
    run("x1", 32'd1, $urandom, 32'd1);
    run("fermat", 32'd3, MODV - 32'd1, 32'd1);
    zinv = K'(pow_mod(64'd3, MOD - 64'd2));
    run("inv", 32'd3, MODV - 32'd2, zinv);
    check("inv_prod", (64'(z) * 64'd3) % MOD, 64'd1);

    // reset while squaring: no done, then a clean run
    dc0 = done_cnt;
    launch(32'd11, 32'hFFFF_FFFF);
    repeat (48) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_z", 64'(z), 64'd0);
    repeat (3 * (T_MUL + 1)) @(posedge clk);
    @(negedge clk);
    check("abort_ndone", 64'(done_cnt - dc0), 64'd0);
    run("after_abort", 32'd7, 32'd2, 32'd49);

    // second start while busy is ignored
    xa  = $urandom % MODV;
    ea  = $urandom;
    dc0 = done_cnt;
    launch(xa, ea);
    repeat (100) @(posedge clk);
    #1;
    x     = 32'd999;
    e     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy_start", cyc);
    check("busy_start_z", 64'(z),
          pow_mod(64'(xa), 64'(ea)));
    repeat (2 * (T_MUL + 1)) @(posedge clk);
    @(negedge clk);
    check("busy_start_ndone", 64'(done_cnt - dc0), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      xa = $urandom % MODV;
      ea = $urandom;
      if (i == 0) ea = ea >> 20;
      if (i == 1) ea = ea >> 9;
      run($sformatf("rnd%0d", i), xa, ea,
          K'(pow_mod(64'(xa), 64'(ea))));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
